// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the decode-side hazard inputs, the EX branch-resolution input and
// the interlock/flush/status outputs of the pipeline hazard controller.
//   master : pipeline side (drives decode info and branch resolution,
//            receives enables, bubble/flush strobes, state and counters)
//   slave  : hazard controller side
// Parameter CNT_W sets the width of the two performance counters and must
// match the controller's CNT_W.
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             dec_valid_In;
  logic [4:0]       dec_rs1_In;
  logic [4:0]       dec_rs2_In;
  logic             dec_rs1_used_In;
  logic             dec_rs2_used_In;
  logic [4:0]       dec_rd_In;
  logic             dec_rd_we_In;
  logic             ex_branch_taken_In;
  logic             pc_write_en_Out;
  logic             if_de_write_en_Out;
  logic             id_ex_bubble_Out;
  logic             if_de_flush_Out;
  logic             id_ex_flush_Out;
  logic [1:0]       state_Out;
  logic [CNT_W-1:0] stall_count_Out;
  logic [CNT_W-1:0] flush_count_Out;

  modport master (
    output dec_valid_In, dec_rs1_In, dec_rs2_In, dec_rs1_used_In,
           dec_rs2_used_In, dec_rd_In, dec_rd_we_In, ex_branch_taken_In,
    input  pc_write_en_Out, if_de_write_en_Out, id_ex_bubble_Out,
           if_de_flush_Out, id_ex_flush_Out, state_Out,
           stall_count_Out, flush_count_Out
  );

  modport slave (
    input  dec_valid_In, dec_rs1_In, dec_rs2_In, dec_rs1_used_In,
           dec_rs2_used_In, dec_rd_In, dec_rd_we_In, ex_branch_taken_In,
    output pc_write_en_Out, if_de_write_en_Out, id_ex_bubble_Out,
           if_de_flush_Out, id_ex_flush_Out, state_Out,
           stall_count_Out, flush_count_Out
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Interlock and flush controller for a 5-stage IF/ID/EX/MA/RW pipeline with no
// forwarding. A 3-entry destination scoreboard shadows ID_EX, EX_MA and MA_RW;
// a decoded instruction whose live source matches a pending destination stalls
// IF and IF_DE and sends a bubble into ID_EX. A taken branch resolved in EX
// kills the instructions in IF_DE and ID (flush beats stall).
// Ports:
//   clk    : pipeline clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave modport of pipeline_hazard_ctrl_if (decode inputs, branch
//            input, enables, bubble/flush strobes, state, counters)
// Parameters:
//   WB_BYPASS : 1 = register file writes through, MA_RW producer never hazards
//   CNT_W     : width of the saturating stall/flush counters
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_entry_t;

  // With write-through the MA_RW entry is already visible in the register
  // file, so only the first two scoreboard entries are searched.
  localparam int NCHK = WB_BYPASS ? 2 : 3;

  sb_entry_t        sb_r [3];
  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             rs1_hit_s;
  logic             rs2_hit_s;
  logic             haz_s;
  logic             flush_s;
  logic             stall_s;

  // Source-register match against the scoreboard and hazard decision.
  always_comb begin
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
    for (int k = 0; k < NCHK; k++) begin
      if (sb_r[k].v && (sb_r[k].rd == bus.dec_rs1_In)) begin
        rs1_hit_s = 1'b1;
      end else begin
        rs1_hit_s = rs1_hit_s;
      end
      if (sb_r[k].v && (sb_r[k].rd == bus.dec_rs2_In)) begin
        rs2_hit_s = 1'b1;
      end else begin
        rs2_hit_s = rs2_hit_s;
      end
    end
    // x0 is hard-wired zero, so it never creates a dependency.
    haz_s = bus.dec_valid_In &
            ((bus.dec_rs1_used_In & (bus.dec_rs1_In != 5'd0) & rs1_hit_s) |
             (bus.dec_rs2_used_In & (bus.dec_rs2_In != 5'd0) & rs2_hit_s));
    flush_s = bus.ex_branch_taken_In;
    // A flush kills the dependent instruction, so it must not also stall.
    stall_s = haz_s & ~flush_s;
  end

  // Pipeline control strobes; these must act in the same cycle as the hazard.
  assign bus.pc_write_en_Out    = ~stall_s;
  assign bus.if_de_write_en_Out = ~stall_s;
  assign bus.id_ex_bubble_Out   = stall_s;
  assign bus.if_de_flush_Out    = flush_s;
  assign bus.id_ex_flush_Out    = flush_s;
  assign bus.state_Out          = state_r;
  assign bus.stall_count_Out    = stall_cnt_r;
  assign bus.flush_count_Out    = flush_cnt_r;

  // Next-state selection: flush has priority over stall.
  always_comb begin
    state_next_s = ST_RUN;
    if (flush_s) begin
      state_next_s = ST_FLUSH;
    end else if (stall_s) begin
      state_next_s = ST_STALL;
    end else begin
      state_next_s = ST_RUN;
    end
  end

  // State register recording the action taken in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Scoreboard shift; downstream stages always advance, only entry 0 is gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        sb_r[k] <= '{v: 1'b0, rd: 5'd0};
      end
    end else begin
      sb_r[2] <= sb_r[1];
      sb_r[1] <= sb_r[0];
      if (flush_s || stall_s) begin
        sb_r[0] <= '{v: 1'b0, rd: 5'd0};
      end else begin
        sb_r[0] <= '{v:  bus.dec_valid_In & bus.dec_rd_we_In & (bus.dec_rd_In != 5'd0),
                     rd: bus.dec_rd_In};
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Three controllers share one directed stimulus stream:
//   dut0 : WB_BYPASS=0, CNT_W=16
//   dut1 : WB_BYPASS=1, CNT_W=16
//   dut2 : WB_BYPASS=0, CNT_W=4   (small counter so saturation is reachable)
// The reference model remembers, per register, the cycle in which its most
// recent writer left ID; a read hazards while that writer is 1..W cycles old
// (W=3 without write-through, W=2 with it).
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs1 = 5'd0;
  logic [4:0] d_rs2 = 5'd0;
  logic       d_u1 = 1'b0;
  logic       d_u2 = 1'b0;
  logic [4:0] d_rd = 5'd0;
  logic       d_we = 1'b0;
  logic       d_br = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) if0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(16)) if1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  if2 ();

  assign if0.dec_valid_In = d_valid;  assign if1.dec_valid_In = d_valid;  assign if2.dec_valid_In = d_valid;
  assign if0.dec_rs1_In = d_rs1;      assign if1.dec_rs1_In = d_rs1;      assign if2.dec_rs1_In = d_rs1;
  assign if0.dec_rs2_In = d_rs2;      assign if1.dec_rs2_In = d_rs2;      assign if2.dec_rs2_In = d_rs2;
  assign if0.dec_rs1_used_In = d_u1;  assign if1.dec_rs1_used_In = d_u1;  assign if2.dec_rs1_used_In = d_u1;
  assign if0.dec_rs2_used_In = d_u2;  assign if1.dec_rs2_used_In = d_u2;  assign if2.dec_rs2_used_In = d_u2;
  assign if0.dec_rd_In = d_rd;        assign if1.dec_rd_In = d_rd;        assign if2.dec_rd_In = d_rd;
  assign if0.dec_rd_we_In = d_we;     assign if1.dec_rd_we_In = d_we;     assign if2.dec_rd_we_In = d_we;
  assign if0.ex_branch_taken_In = d_br; assign if1.ex_branch_taken_In = d_br; assign if2.ex_branch_taken_In = d_br;

  pipeline_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  pipeline_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  pipeline_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // Gathered DUT outputs, counters zero-extended to 16 bits.
  logic        o_pc [3];
  logic        o_ifde [3];
  logic        o_bub [3];
  logic        o_iff [3];
  logic        o_idf [3];
  logic [1:0]  o_st [3];
  logic [15:0] o_sc [3];
  logic [15:0] o_fc [3];

  assign o_pc[0] = if0.pc_write_en_Out;    assign o_pc[1] = if1.pc_write_en_Out;    assign o_pc[2] = if2.pc_write_en_Out;
  assign o_ifde[0] = if0.if_de_write_en_Out; assign o_ifde[1] = if1.if_de_write_en_Out; assign o_ifde[2] = if2.if_de_write_en_Out;
  assign o_bub[0] = if0.id_ex_bubble_Out;  assign o_bub[1] = if1.id_ex_bubble_Out;  assign o_bub[2] = if2.id_ex_bubble_Out;
  assign o_iff[0] = if0.if_de_flush_Out;   assign o_iff[1] = if1.if_de_flush_Out;   assign o_iff[2] = if2.if_de_flush_Out;
  assign o_idf[0] = if0.id_ex_flush_Out;   assign o_idf[1] = if1.id_ex_flush_Out;   assign o_idf[2] = if2.id_ex_flush_Out;
  assign o_st[0] = if0.state_Out;          assign o_st[1] = if1.state_Out;          assign o_st[2] = if2.state_Out;
  assign o_sc[0] = if0.stall_count_Out;    assign o_sc[1] = if1.stall_count_Out;    assign o_sc[2] = {12'd0, if2.stall_count_Out};
  assign o_fc[0] = if0.flush_count_Out;    assign o_fc[1] = if1.flush_count_Out;    assign o_fc[2] = {12'd0, if2.flush_count_Out};

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0;
  int last_wr [3][32];   // cycle in which the latest writer of each reg issued
  int m_prev [3];        // previous-cycle action 0 run, 1 stall, 2 flush
  int m_sc [3];
  int m_fc [3];
  int win [3]  = '{3, 2, 3};
  int cmax [3] = '{65535, 65535, 15};

  function automatic bit m_haz(input int i);
    bit h1;
    bit h2;
    h1 = d_u1 && (d_rs1 != 5'd0) && ((cyc - last_wr[i][d_rs1]) <= win[i]);
    h2 = d_u2 && (d_rs2 != 5'd0) && ((cyc - last_wr[i][d_rs2]) <= win[i]);
    return d_valid && (h1 || h2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int r = 0; r < 32; r++) last_wr[i][r] = -100;
        m_prev[i] = 0;
        m_sc[i] = 0;
        m_fc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit st;
        st = m_haz(i) && !d_br;
        if (st && m_sc[i] < cmax[i]) m_sc[i]++;
        if (d_br && m_fc[i] < cmax[i]) m_fc[i]++;
        m_prev[i] = d_br ? 2 : (st ? 1 : 0);
        if (!st && !d_br && d_valid && d_we && d_rd != 5'd0) last_wr[i][d_rd] = cyc;
      end
      cyc++;
    end
  end

  // Compare every output of every instance against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        bit st;
        st = m_haz(i) && !d_br;
        chk($sformatf("dut%0d pc_write_en", i), int'(o_pc[i]), int'(!st));
        chk($sformatf("dut%0d if_de_write_en", i), int'(o_ifde[i]), int'(!st));
        chk($sformatf("dut%0d id_ex_bubble", i), int'(o_bub[i]), int'(st));
        chk($sformatf("dut%0d if_de_flush", i), int'(o_iff[i]), int'(d_br));
        chk($sformatf("dut%0d id_ex_flush", i), int'(o_idf[i]), int'(d_br));
        chk($sformatf("dut%0d state", i), int'(o_st[i]), m_prev[i]);
        chk($sformatf("dut%0d stall_count", i), int'(o_sc[i]), m_sc[i]);
        chk($sformatf("dut%0d flush_count", i), int'(o_fc[i]), m_fc[i]);
      end
    end
  end

  // Hold one decode vector for one clock cycle.
  task automatic apply(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic br);
    d_valid = v; d_rs1 = rs1; d_u1 = u1; d_rs2 = rs2; d_u2 = u2;
    d_rd = rd; d_we = we; d_br = br;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_counts(input string tag, input int s0, input int s1, input int s2);
    chk({tag, " dut0 stall_count"}, int'(o_sc[0]), s0);
    chk({tag, " dut1 stall_count"}, int'(o_sc[1]), s1);
    chk({tag, " dut2 stall_count"}, int'(o_sc[2]), s2);
  endtask

  initial begin
    // 1: reset
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset pc_write_en", int'(o_pc[0]), 1);
    chk("reset bubble", int'(o_bub[0]), 0);
    chk("reset state", int'(o_st[0]), 0);
    chk_counts("reset", 0, 0, 0);
    rst_n = 1'b1;
    idle(2);

    // 2/3: producer rd=5 directly ahead of consumer rs1=5
    apply(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) apply(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0);
    idle(4);
    chk_counts("adjacent RAW", 3, 2, 3);

    // 3: producer rd=7 two instructions ahead of consumer rs2=7
    apply(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    apply(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) apply(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b0, 1'b0);
    idle(4);
    chk_counts("distance-2 RAW", 5, 3, 5);

    // 4: rd=0 producer, unused rs2, invalid consumer -> no stalls
    apply(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    apply(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    apply(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    apply(1'b1, 5'd3, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
    apply(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    apply(1'b0, 5'd10, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(4);
    chk_counts("no-hazard cases", 5, 3, 5);

    // 5: branch in the same cycle as a live hazard
    apply(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    d_valid = 1'b1; d_rs1 = 5'd11; d_u1 = 1'b1; d_rs2 = 5'd0; d_u2 = 1'b0;
    d_rd = 5'd12; d_we = 1'b1; d_br = 1'b1;
    #2;
    chk("flush if_de_flush", int'(o_iff[0]), 1);
    chk("flush pc_write_en", int'(o_pc[0]), 1);
    chk("flush bubble", int'(o_bub[0]), 0);
    @(posedge clk); #1;
    chk("after flush state", int'(o_st[0]), 2);
    chk("after flush dut1 flush_count", int'(o_fc[1]), 1);
    // killed instruction's rd=12 must not be pending
    apply(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(4);
    chk_counts("after flush", 5, 3, 5);

    // 6: reset pulse during the second stall cycle
    apply(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    apply(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    chk("2nd stall pc_write_en", int'(o_pc[0]), 0);
    rst_n = 1'b0;
    #1;
    chk("async reset pc_write_en", int'(o_pc[0]), 1);
    chk("async reset bubble", int'(o_bub[0]), 0);
    chk("async reset state", int'(o_st[0]), 0);
    chk("async reset flush_count", int'(o_fc[0]), 0);
    chk_counts("async reset", 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // 6: saturation of the 4-bit stall counter
    for (int p = 0; p < 6; p++) begin
      apply(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) apply(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    end
    chk_counts("saturate", 18, 12, 15);
    apply(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) apply(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_counts("hold saturated", 21, 14, 15);
    idle(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
